i2s_adc_receiver: RTL and testbench
===================================

# i2s_adc_receiver

Capture path for the WM8731 ADC. The block generates the I2S bit clock and ADC left/right clock as FPGA master from CLOCK_50, and deserialises AUD_ADCDAT into parallel 16-bit left/right samples. It presents each captured stereo frame on a valid/ready interface toward the audio datapath, and it is the receive counterpart of the existing DAC serialiser in Audio_Codec.

## Interface
- BCLK_HALF, 8: CLOCK_50 cycles per BCLK half-period (≥4); default BCLK = 3.125 MHz.
- DATA_WIDTH, 16: sample bits captured per channel (1..31), MSB first.
- CLOCK_50 input 1: single system clock; all logic on its rising edge.
- RESET input 1: reset is synchronous and active-high.
- AUD_ADCDAT input 1: serial data from codec (asynchronous to CLOCK_50, two-flop synchronised).
- AUD_BCLK output 1: generated bit clock.
- AUD_ADCLRCK output 1: channel clock; 0 = left slot, 1 = right slot.
- LEFT_DATA output DATA_WIDTH: last completed left sample.
- RIGHT_DATA output DATA_WIDTH: last completed right sample.
- SAMPLE_VALID output 1: LEFT_DATA/RIGHT_DATA hold an unconsumed frame.
- SAMPLE_READY input 1: consumer accepts frame when high with SAMPLE_VALID.
- OVERRUN output 1: sticky; a frame was overwritten before being accepted.

## Operation
- Divider div_cnt counts 0..BCLK_HALF-1, wraps; on wrap, AUD_BCLK toggles on the next edge. "Rise event" = cycle AUD_BCLK goes 0→1; "fall event" = 1→0.
- Slot counter bit_cnt (6 bits, 0..63) advances on each fall event, wraps 63→0. AUD_ADCLRCK = bit_cnt[5], updated in the same cycle as bit_cnt (changes only on fall events).
- Slot index s = bit_cnt[4:0]. I2S format: MSB is on slot s=1 (one BCLK after LRCK change).
- On each rise event with 1 ≤ s ≤ DATA_WIDTH: shift synchronised ADCDAT into left shifter (LRCK=0) or right shifter (LRCK=1), MSB first. Bits in s=0 and s>DATA_WIDTH are ignored.
- At the rise event with s=DATA_WIDTH, LRCK=0: left shifter copied to a left holding register.
- At the rise event with s=DATA_WIDTH, LRCK=1: on the next cycle, LEFT_DATA ← left holding register, RIGHT_DATA ← completed right shifter, SAMPLE_VALID ← 1.
- Handshake: transfer occurs on any cycle with SAMPLE_VALID & SAMPLE_READY. SAMPLE_VALID then clears next cycle unless a new frame loads in the same cycle, in which case it stays 1.
- Overrun: a frame load while SAMPLE_VALID=1 and SAMPLE_READY=0 sets OVERRUN=1 and overwrites the data (newest frame wins). OVERRUN clears only on RESET.
- Outputs LEFT_DATA/RIGHT_DATA are stable while SAMPLE_VALID=1, except on an overrun load.

## Timing
- Reset values: AUD_BCLK=0, AUD_ADCLRCK=0, LEFT_DATA=0, RIGHT_DATA=0, SAMPLE_VALID=0, OVERRUN=0; div_cnt=0, bit_cnt=0, shifters/synchroniser cleared.
- First rise event occurs BCLK_HALF cycles after RESET deasserts. The first frame begins at bit_cnt=0 (left, s=0).
- BCLK period = 2·BCLK_HALF cycles (16). Frame = 64 BCLK = 128·BCLK_HALF cycles (1024; 48.83 kHz).
- ADCDAT sampling point: synchroniser output at the rise event. This reflects the pin value 2 cycles earlier, i.e. ≥ BCLK_HALF-2 cycles after the codec's fall-edge update.
- Frame latency: SAMPLE_VALID rises 1 cycle after the right-channel s=DATA_WIDTH rise event. For defaults, that is cycle 8+16·(32+16)+1 = 777 after reset release for the first frame.
- RESET mid-frame: all state returns to reset values on the next edge. Partial shifts are discarded and the framing restarts at left s=0.

## Test plan
- Reset/clocking: hold RESET 3 cycles, release -> all outputs 0; AUD_BCLK period 16 cycles; AUD_ADCLRCK toggles every 512 cycles, only on BCLK falling edges.
- Single frame: codec model drives left=16'hA5C3, right=16'h3C5A in I2S format, SAMPLE_READY=1 -> SAMPLE_VALID pulses high exactly 1 cycle at cycle 777 with LEFT_DATA=A5C3, RIGHT_DATA=3C5A, OVERRUN=0.
- Padding immunity: drive 1s on s=0 and s=17..31 around left=0000/right=FFFF -> captured 0000/FFFF.
- Backpressure/overrun: SAMPLE_READY=0 for two frames (1111/2222 then 3333/4444) -> SAMPLE_VALID stays 1, data becomes 3333/4444, OVERRUN=1; assert READY 1 cycle -> VALID 0, OVERRUN stays 1.
- Same-cycle accept and load: SAMPLE_READY rises in the exact cycle a new frame loads -> SAMPLE_VALID stays 1, new data present, OVERRUN=0.
- Reset mid-frame: assert RESET at left s=8 of a frame -> outputs 0 next cycle; after release, first valid frame matches only fully transmitted post-reset data.

Source files
------------

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
//   I2S capture path for the WM8731 ADC with the FPGA as clock master.
//   Generates AUD_BCLK / AUD_ADCLRCK from CLOCK_50 and deserialises
//   AUD_ADCDAT (MSB first, one BCLK after the LRCK edge) into parallel
//   left/right samples. Each completed stereo frame is offered on a
//   valid/ready interface.
//
// Ports
//   CLOCK_50      in   system clock, all logic on its rising edge
//   RESET         in   synchronous, active-high
//   AUD_ADCDAT    in   serial data from codec (asynchronous, 2-flop sync)
//   AUD_BCLK      out  bit clock, period 2*BCLK_HALF system cycles
//   AUD_ADCLRCK   out  channel clock, 0 = left slot, 1 = right slot
//   LEFT_DATA     out  last completed left sample
//   RIGHT_DATA    out  last completed right sample
//   SAMPLE_VALID  out  LEFT_DATA/RIGHT_DATA hold an unconsumed frame
//   SAMPLE_READY  in   consumer accepts the frame when high with VALID
//   OVERRUN       out  sticky, a frame was overwritten before acceptance
module i2s_adc_receiver #(
  parameter int BCLK_HALF  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  AUD_ADCDAT,
  output logic                  AUD_BCLK,
  output logic                  AUD_ADCLRCK,
  output logic [DATA_WIDTH-1:0] LEFT_DATA,
  output logic [DATA_WIDTH-1:0] RIGHT_DATA,
  output logic                  SAMPLE_VALID,
  input  logic                  SAMPLE_READY,
  output logic                  OVERRUN
);

  localparam int DIV_W = $clog2(BCLK_HALF);

  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            bit_cnt;
  logic                  adc_s1, adc_s2;
  logic [DATA_WIDTH-1:0] left_sh, right_sh, left_hold;
  logic                  frame_done;

  logic                  half_end, rise, fall;
  logic [4:0]            slot;
  logic                  in_word, word_end;
  logic [DATA_WIDTH-1:0] left_next, right_next;

  // BCLK toggles when the divider wraps; the edge direction is known from
  // the current BCLK level, so rise/fall are decoded one cycle ahead and
  // act on the same clock edge that flips AUD_BCLK.
  assign half_end = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign rise     = half_end & ~AUD_BCLK;
  assign fall     = half_end &  AUD_BCLK;

  assign AUD_ADCLRCK = bit_cnt[5];
  assign slot        = bit_cnt[4:0];
  // Slot 0 carries the previous word's trailing bit in I2S; slots past the
  // word width are padding.
  assign in_word     = (slot != 5'd0) && ({1'b0, slot} <= 6'(DATA_WIDTH));
  assign word_end    = (slot == 5'(DATA_WIDTH));

  assign left_next   = DATA_WIDTH'({left_sh,  adc_s2});
  assign right_next  = DATA_WIDTH'({right_sh, adc_s2});

  // Clock generation and slot counting
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      div_cnt  <= '0;
      AUD_BCLK <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      if (half_end) begin
        div_cnt  <= '0;
        AUD_BCLK <= ~AUD_BCLK;
      end else begin
        div_cnt  <= div_cnt + DIV_W'(1);
      end
      if (fall)
        bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // Input synchroniser and per-channel deserialisers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      adc_s1     <= 1'b0;
      adc_s2     <= 1'b0;
      left_sh    <= '0;
      right_sh   <= '0;
      left_hold  <= '0;
      frame_done <= 1'b0;
    end else begin
      adc_s1     <= AUD_ADCDAT;
      adc_s2     <= adc_s1;
      frame_done <= rise & word_end & bit_cnt[5];
      if (rise && in_word) begin
        if (bit_cnt[5]) right_sh <= right_next;
        else            left_sh  <= left_next;
      end
      // Left word is parked so the left shifter is free while right arrives.
      if (rise && word_end && !bit_cnt[5])
        left_hold <= left_next;
    end
  end

  // Output frame register and handshake. A load always wins over an
  // accept in the same cycle, so VALID stays high for the new frame.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      LEFT_DATA    <= '0;
      RIGHT_DATA   <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else if (frame_done) begin
      LEFT_DATA    <= left_hold;
      RIGHT_DATA   <= right_sh;
      SAMPLE_VALID <= 1'b1;
      if (SAMPLE_VALID && !SAMPLE_READY)
        OVERRUN <= 1'b1;
    end else if (SAMPLE_VALID && SAMPLE_READY) begin
      SAMPLE_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Testbench for i2s_adc_receiver: an I2S slave codec model driving
// AUD_ADCDAT from the DUT's BCLK/LRCK, and a frame-level reference model
// that predicts clock outputs and the valid/ready frame interface from
// cycle arithmetic.
module tb_i2s_adc_receiver;

  localparam int BH    = 8;
  localparam int DW    = 16;
  localparam int FRAME = 128 * BH;
  localparam int LAT   = BH + 2 * BH * (32 + DW) + 1;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        pad1;
  } frame_t;

  logic          CLOCK_50 = 1'b0;
  logic          RESET = 1'b1;
  logic          AUD_ADCDAT;
  logic          AUD_BCLK, AUD_ADCLRCK;
  logic [DW-1:0] LEFT_DATA, RIGHT_DATA;
  logic          SAMPLE_VALID;
  logic          SAMPLE_READY = 1'b0;
  logic          OVERRUN;

  i2s_adc_receiver #(.BCLK_HALF(BH), .DATA_WIDTH(DW)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET       (RESET),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .LEFT_DATA   (LEFT_DATA),
    .RIGHT_DATA  (RIGHT_DATA),
    .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Inputs as seen by the DUT at the last rising edge
  logic rst_q = 1'b1;
  logic rdy_q = 1'b0;
  always @(posedge CLOCK_50) begin
    rst_q <= RESET;
    rdy_q <= SAMPLE_READY;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- codec model (I2S slave) ----------------
  frame_t tx_q[$];    // frames requested by the test
  frame_t sent_q[$];  // frames actually started since the last reset
  frame_t cur;
  int     slot;
  logic   lr_prev, bclk_prev;
  bit     need_new;

  function automatic frame_t next_frame();
    frame_t f;
    if (tx_q.size() != 0) begin
      f = tx_q.pop_front();
    end else begin
      f.l    = 16'($urandom);
      f.r    = 16'($urandom);
      f.pad1 = 1'b0;
    end
    return f;
  endfunction

  function automatic logic bit_for(int s, logic lr);
    if (s >= 1 && s <= DW) return lr ? cur.r[DW-s] : cur.l[DW-s];
    return cur.pad1 ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // The codec updates its data on BCLK falling edges; a new frame starts
  // whenever LRCK returns to the left slot (or the link comes out of reset).
  always @(negedge CLOCK_50) begin
    if (rst_q) begin
      slot = 0; lr_prev = 1'b0; bclk_prev = 1'b0; need_new = 1'b1;
      sent_q.delete();
      AUD_ADCDAT = 1'b0;
    end else begin
      if (need_new) begin
        cur = next_frame();
        sent_q.push_back(cur);
        need_new = 1'b0;
        AUD_ADCDAT = bit_for(0, 1'b0);
      end
      if (bclk_prev && !AUD_BCLK) begin
        if (AUD_ADCLRCK != lr_prev) begin
          slot = 0;
          if (!AUD_ADCLRCK) begin
            cur = next_frame();
            sent_q.push_back(cur);
          end
        end else begin
          slot++;
        end
        lr_prev = AUD_ADCLRCK;
        AUD_ADCDAT = bit_for(slot, lr_prev);
      end
      bclk_prev = AUD_BCLK;
    end
  end

  // ---------------- reference model ----------------
  // cyc = rising edges since reset release; frame n lands at LAT + n*FRAME.
  int          cyc = 0;
  int          ld_n = 0;
  logic        ev = 1'b0, eo = 1'b0;
  logic [15:0] el = '0, er = '0;

  task automatic tick();
    logic [1:0] exp_clk;
    @(negedge CLOCK_50);
    if (rst_q) begin
      cyc = 0; ld_n = 0; ev = 1'b0; eo = 1'b0; el = '0; er = '0;
    end else begin
      cyc++;
      if (cyc == LAT + FRAME * ld_n) begin
        if (ev && !rdy_q) eo = 1'b1;
        ev = 1'b1;
        if (ld_n < sent_q.size()) begin
          el = sent_q[ld_n].l;
          er = sent_q[ld_n].r;
        end
        ld_n++;
      end else if (ev && rdy_q) begin
        ev = 1'b0;
      end
    end
    exp_clk = {((cyc / BH) % 2) == 1, ((cyc / (FRAME / 2)) % 2) == 1};
    chk("clk", {AUD_BCLK, AUD_ADCLRCK}, exp_clk);
    chk("frame", {SAMPLE_VALID, OVERRUN, LEFT_DATA, RIGHT_DATA}, {ev, eo, el, er});
  endtask

  task automatic run_to(input int n, input bit rand_rdy);
    while (cyc < n) begin
      if (rand_rdy) SAMPLE_READY = ($urandom_range(0, 3) == 0);
      tick();
    end
  endtask

  initial begin
    tx_q.push_back(frame_t'{16'hA5C3, 16'h3C5A, 1'b0});
    tx_q.push_back(frame_t'{16'h0000, 16'hFFFF, 1'b1});
    tx_q.push_back(frame_t'{16'h1111, 16'h2222, 1'b0});
    tx_q.push_back(frame_t'{16'h3333, 16'h4444, 1'b0});

    // reset and first frame
    repeat (3) tick();
    chk("rst_outs", {SAMPLE_VALID, OVERRUN, LEFT_DATA, RIGHT_DATA, AUD_BCLK, AUD_ADCLRCK}, '0);
    RESET = 1'b0;
    SAMPLE_READY = 1'b1;
    run_to(BH, 1'b0);
    chk("first_rise", AUD_BCLK, 1'b1);
    run_to(LAT - 1, 1'b0);
    chk("pre_valid", SAMPLE_VALID, 1'b0);
    tick();
    chk("first_valid", {SAMPLE_VALID, OVERRUN}, 2'b10);
    chk("first_l", LEFT_DATA, 16'hA5C3);
    chk("first_r", RIGHT_DATA, 16'h3C5A);
    tick();
    chk("valid_pulse", SAMPLE_VALID, 1'b0);

    // padding immunity
    run_to(LAT + FRAME, 1'b0);
    chk("pad_data", {LEFT_DATA, RIGHT_DATA}, {16'h0000, 16'hFFFF});
    tick();
    SAMPLE_READY = 1'b0;

    // backpressure over two frames
    run_to(LAT + 3 * FRAME + 5, 1'b0);
    chk("bp_state", {SAMPLE_VALID, OVERRUN}, 2'b11);
    chk("bp_data", {LEFT_DATA, RIGHT_DATA}, {16'h3333, 16'h4444});
    SAMPLE_READY = 1'b1;
    tick();
    SAMPLE_READY = 1'b0;
    chk("bp_accept", {SAMPLE_VALID, OVERRUN}, 2'b01);

    // accept in the same cycle a new frame loads
    RESET = 1'b1;
    repeat (2) tick();
    chk("rst2_ovr", OVERRUN, 1'b0);
    RESET = 1'b0;
    run_to(LAT + FRAME - 1, 1'b0);
    chk("hold_valid", SAMPLE_VALID, 1'b1);
    SAMPLE_READY = 1'b1;
    tick();
    chk("same_cycle", {SAMPLE_VALID, OVERRUN}, 2'b10);
    chk("same_data", {LEFT_DATA, RIGHT_DATA}, {sent_q[1].l, sent_q[1].r});

    // random handshake traffic
    run_to(LAT + 6 * FRAME, 1'b1);

    // reset in the middle of the left word (s = 8)
    while ((cyc % FRAME) != 8 * 2 * BH + 2) begin
      SAMPLE_READY = ($urandom_range(0, 3) == 0);
      tick();
    end
    RESET = 1'b1;
    tx_q.push_back(frame_t'{16'hBEEF, 16'h1234, 1'b0});
    tick();
    chk("midrst_outs", {SAMPLE_VALID, OVERRUN, LEFT_DATA, RIGHT_DATA}, '0);
    tick();
    RESET = 1'b0;
    SAMPLE_READY = 1'b1;
    run_to(LAT, 1'b0);
    chk("midrst_data", {SAMPLE_VALID, LEFT_DATA, RIGHT_DATA}, {1'b1, 16'hBEEF, 16'h1234});
    run_to(LAT + 2 * FRAME, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
